// File: rtl/bsg_dmc_axi_bridge.sv
// rtl/bsg_dmc_axi_bridge.sv - DMC command/write/read FIFOs to AXI4 master bridge with per-bank row tracking
// Optional feature macro: BSG_DMC_AXI_RESP_CHECK_EN (flag non-OKAY B/R responses and misplaced rlast)

module bsg_dmc_axi_bridge_len_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, rptr_q;
    logic [cnt_w_lp-1:0] cnt_q;
    logic                push, pop;

    assign v_o    = (cnt_q != '0);
    assign data_o = mem_q[rptr_q];
    assign push   = v_i && (cnt_q != cnt_w_lp'(els_p));
    assign pop    = yumi_i && v_o;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= next_ptr(wptr_q);
            end
            if (pop) begin
                rptr_q <= next_ptr(rptr_q);
            end
            cnt_q <= cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
        end
    end
endmodule

module bsg_dmc_axi_bridge #(
    parameter int dq_data_width_p   = 32,
    parameter int axi_id_width_p    = 6,
    parameter int axi_addr_width_p  = 32,
    parameter int axi_data_width_p  = 64,
    parameter int bank_width_p      = 3,
    parameter int row_width_p       = 14,
    parameter int col_width_p       = 10,
    parameter int max_outstanding_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic                            cmd_v_i,
    input  logic [bank_width_p+16+7-1:0]    cmd_data_i,
    output logic                            cmd_ready_o,

    input  logic                            wr_v_i,
    input  logic [2*dq_data_width_p+2*dq_data_width_p/8-1:0] wr_data_i,
    output logic                            wr_ready_o,

    output logic                            rd_v_o,
    output logic [2*dq_data_width_p-1:0]    rd_data_o,
    input  logic                            rd_yumi_i,

    output logic [axi_id_width_p-1:0]       axi_awid_o,
    output logic [axi_addr_width_p-1:0]     axi_awaddr_o,
    output logic [7:0]                      axi_awlen_o,
    output logic [2:0]                      axi_awsize_o,
    output logic [1:0]                      axi_awburst_o,
    output logic                            axi_awvalid_o,
    input  logic                            axi_awready_i,

    output logic [axi_data_width_p-1:0]     axi_wdata_o,
    output logic [axi_data_width_p/8-1:0]   axi_wstrb_o,
    output logic                            axi_wlast_o,
    output logic                            axi_wvalid_o,
    input  logic                            axi_wready_i,

    input  logic [axi_id_width_p-1:0]       axi_bid_i,
    input  logic [1:0]                      axi_bresp_i,
    input  logic                            axi_bvalid_i,
    output logic                            axi_bready_o,

    output logic [axi_id_width_p-1:0]       axi_arid_o,
    output logic [axi_addr_width_p-1:0]     axi_araddr_o,
    output logic [7:0]                      axi_arlen_o,
    output logic [2:0]                      axi_arsize_o,
    output logic [1:0]                      axi_arburst_o,
    output logic                            axi_arvalid_o,
    input  logic                            axi_arready_i,

    input  logic [axi_id_width_p-1:0]       axi_rid_i,
    input  logic [axi_data_width_p-1:0]     axi_rdata_i,
    input  logic [1:0]                      axi_rresp_i,
    input  logic                            axi_rlast_i,
    input  logic                            axi_rvalid_i,
    output logic                            axi_rready_o,

    output logic                            error_o
);
    localparam int dqw_lp      = 2 * dq_data_width_p;
    localparam int maskw_lp    = dqw_lp / 8;
    localparam int wr_w_lp     = dqw_lp + maskw_lp;
    localparam int ratio_lp    = axi_data_width_p / dqw_lp;
    localparam int ratio_lg_lp = $clog2(ratio_lp);
    localparam int pk_w_lp     = $clog2(ratio_lp + 1);
    localparam int cmd_w_lp    = bank_width_p + 16 + 7;
    localparam int bank_els_lp = 1 << bank_width_p;
    localparam int cnt_w_lp    = $clog2(max_outstanding_p + 1);
    localparam int bytes_lp    = dq_data_width_p / 8;
    localparam int lin_w_lp    = bank_width_p + row_width_p + col_width_p + $clog2(bytes_lp);
    localparam int addr_w_lp   = (lin_w_lp > axi_addr_width_p) ? lin_w_lp : axi_addr_width_p;

    // Command field decode
    logic [bank_width_p-1:0] c_bank;
    logic [15:0]             c_addr;
    logic [3:0]              c_op;
    logic is_act, is_pre, is_rd, is_wr, is_mrs, bank_open, mrs_code_ok;

    assign c_bank      = cmd_data_i[cmd_w_lp-1 -: bank_width_p];
    assign c_addr      = cmd_data_i[22:7];
    assign c_op        = cmd_data_i[5:2];
    assign is_act      = (c_op == 4'b0011);
    assign is_pre      = (c_op == 4'b0010);
    assign is_rd       = (c_op == 4'b0101);
    assign is_wr       = (c_op == 4'b0100);
    assign is_mrs      = (c_op == 4'b0000);
    assign mrs_code_ok = (c_addr[2:0] >= 3'b001) && (c_addr[2:0] <= 3'b100);

    logic [row_width_p-1:0] row_q [bank_els_lp];
    logic [bank_els_lp-1:0] open_q;
    logic [4:0]             bl_q;
    logic                   error_q, error_d;
    logic [cnt_w_lp-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    assign bank_open = open_q[c_bank];

    logic [addr_w_lp-1:0] addr_full;
    logic [4:0]           beats;
    logic [7:0]           burst_len;

    assign addr_full = addr_w_lp'({c_bank, row_q[c_bank], c_addr[col_width_p-1:0]}) * addr_w_lp'(bytes_lp);
    assign beats     = bl_q >> (ratio_lg_lp + 1);
    assign burst_len = (beats == 5'd0) ? 8'd0 : 8'(beats - 5'd1);

    logic rd_room, wr_room, ar_hs, aw_hs;
    assign rd_room = (rd_cnt_q != cnt_w_lp'(max_outstanding_p));
    assign wr_room = (wr_cnt_q != cnt_w_lp'(max_outstanding_p));

    assign axi_arid_o    = '0;
    assign axi_araddr_o  = addr_full[axi_addr_width_p-1:0];
    assign axi_arlen_o   = burst_len;
    assign axi_arsize_o  = 3'($clog2(axi_data_width_p / 8));
    assign axi_arburst_o = 2'b01;
    assign axi_arvalid_o = cmd_v_i && is_rd && bank_open && rd_room;

    assign axi_awid_o    = '0;
    assign axi_awaddr_o  = addr_full[axi_addr_width_p-1:0];
    assign axi_awlen_o   = burst_len;
    assign axi_awsize_o  = 3'($clog2(axi_data_width_p / 8));
    assign axi_awburst_o = 2'b01;
    assign axi_awvalid_o = cmd_v_i && is_wr && bank_open && wr_room;

    assign ar_hs = axi_arvalid_o && axi_arready_i;
    assign aw_hs = axi_awvalid_o && axi_awready_i;

    // RD/WR to an open bank wait for the AXI handshake; everything else drains at once
    always_comb begin
        cmd_ready_o = 1'b1;
        if (is_rd && bank_open) begin
            cmd_ready_o = axi_arready_i && rd_room;
        end else if (is_wr && bank_open) begin
            cmd_ready_o = axi_awready_i && wr_room;
        end
    end

    // Write path: length FIFO plus SIPO packing FIFO words into W beats
    logic                          wlen_v;
    logic [7:0]                    wlen_data, wbeat_q;
    logic [axi_data_width_p-1:0]   sipo_data_q;
    logic [axi_data_width_p/8-1:0] sipo_strb_q;
    logic [pk_w_lp-1:0]            sipo_cnt_q;
    logic                          sipo_full, wr_hs, w_hs;

    assign sipo_full    = (sipo_cnt_q == pk_w_lp'(ratio_lp));
    assign wr_ready_o   = !sipo_full;
    assign wr_hs        = wr_v_i && wr_ready_o;
    assign axi_wvalid_o = sipo_full && wlen_v;
    assign axi_wdata_o  = sipo_data_q;
    assign axi_wstrb_o  = sipo_strb_q;
    assign axi_wlast_o  = (wbeat_q == wlen_data);
    assign w_hs         = axi_wvalid_o && axi_wready_i;

    bsg_dmc_axi_bridge_len_fifo #(.els_p(max_outstanding_p), .width_p(8)) wlen_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (aw_hs),
        .data_i  (burst_len),
        .yumi_i  (w_hs && axi_wlast_o),
        .v_o     (wlen_v),
        .data_o  (wlen_data)
    );

    logic b_hs, b_done;
    assign axi_bready_o = 1'b1;
    assign b_hs         = axi_bvalid_i && axi_bready_o;
    assign b_done       = b_hs && (wr_cnt_q != '0);

    // Read path: beat counter against the length FIFO, PISO unpacks low word first
    logic                        rlen_v, r_hs, r_final, r_done;
    logic [7:0]                  rlen_data, rbeat_q;
    logic [axi_data_width_p-1:0] piso_q;
    logic [pk_w_lp-1:0]          piso_cnt_q;

    assign axi_rready_o = (piso_cnt_q == '0);
    assign r_hs         = axi_rvalid_i && axi_rready_o;
    assign r_final      = (rbeat_q == rlen_data);
    assign r_done       = r_hs && rlen_v && r_final;
    assign rd_v_o       = (piso_cnt_q != '0);
    assign rd_data_o    = piso_q[dqw_lp-1:0];

    bsg_dmc_axi_bridge_len_fifo #(.els_p(max_outstanding_p), .width_p(8)) rlen_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (ar_hs),
        .data_i  (burst_len),
        .yumi_i  (r_done),
        .v_o     (rlen_v),
        .data_o  (rlen_data)
    );

    assign rd_cnt_d = rd_cnt_q + cnt_w_lp'(ar_hs) - cnt_w_lp'(r_done);
    assign wr_cnt_d = wr_cnt_q + cnt_w_lp'(aw_hs) - cnt_w_lp'(b_done);

    always_comb begin
        error_d = error_q;
        if (cmd_v_i && is_mrs && !mrs_code_ok) error_d = 1'b1;
        if (cmd_v_i && (is_rd || is_wr) && !bank_open) error_d = 1'b1;
`ifdef BSG_DMC_AXI_RESP_CHECK_EN
        if (b_hs && (axi_bresp_i != 2'b00)) error_d = 1'b1;
        if (r_hs && ((axi_rresp_i != 2'b00) || !rlen_v || (axi_rlast_i != r_final))) error_d = 1'b1;
`endif
    end

    assign error_o = error_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            open_q      <= '0;
            bl_q        <= 5'd8;
            error_q     <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            wbeat_q     <= '0;
            rbeat_q     <= '0;
            sipo_data_q <= '0;
            sipo_strb_q <= '0;
            sipo_cnt_q  <= '0;
            piso_q      <= '0;
            piso_cnt_q  <= '0;
        end else begin
            error_q  <= error_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;

            if (cmd_v_i && is_act) begin
                row_q[c_bank]  <= c_addr[row_width_p-1:0];
                open_q[c_bank] <= 1'b1;
            end
            if (cmd_v_i && is_pre) begin
                if (c_addr[10]) open_q <= '0;
                else            open_q[c_bank] <= 1'b0;
            end
            if (cmd_v_i && is_mrs) begin
                case (c_addr[2:0])
                    3'b001:  bl_q <= 5'd2;
                    3'b010:  bl_q <= 5'd4;
                    3'b011:  bl_q <= 5'd8;
                    3'b100:  bl_q <= 5'd16;
                    default: bl_q <= bl_q;
                endcase
            end

            if (wr_hs) begin
                for (int i = 0; i < ratio_lp; i++) begin
                    if (sipo_cnt_q == pk_w_lp'(i)) begin
                        sipo_data_q[i*dqw_lp +: dqw_lp]     <= wr_data_i[wr_w_lp-1 -: dqw_lp];
                        sipo_strb_q[i*maskw_lp +: maskw_lp] <= wr_data_i[maskw_lp-1:0];
                    end
                end
                sipo_cnt_q <= sipo_cnt_q + 1'b1;
            end else if (w_hs) begin
                sipo_cnt_q <= '0;
            end
            if (w_hs) begin
                wbeat_q <= axi_wlast_o ? 8'd0 : wbeat_q + 8'd1;
            end

            if (r_hs) begin
                piso_q     <= axi_rdata_i;
                piso_cnt_q <= pk_w_lp'(ratio_lp);
                if (rlen_v) rbeat_q <= r_final ? 8'd0 : rbeat_q + 8'd1;
            end else if (rd_v_o && rd_yumi_i) begin
                for (int i = 0; i < ratio_lp - 1; i++) begin
                    piso_q[i*dqw_lp +: dqw_lp] <= piso_q[(i+1)*dqw_lp +: dqw_lp];
                end
                piso_cnt_q <= piso_cnt_q - 1'b1;
            end
        end
    end

    // IDs, side-band command bits and (without response checking) resp/rlast carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{axi_bid_i, axi_rid_i, axi_bresp_i, axi_rresp_i, axi_rlast_i,
                           cmd_data_i, addr_full};
endmodule

// File: tb/tb_bsg_dmc_axi_bridge.sv
// tb/tb_bsg_dmc_axi_bridge.sv - directed self-checking bench for bsg_dmc_axi_bridge
module tb_bsg_dmc_axi_bridge;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        cmd_v_i;
    logic [25:0] cmd_data_i;
    logic        cmd_ready_o;
    logic        wr_v_i;
    logic [71:0] wr_data_i;
    logic        wr_ready_o;
    logic        rd_v_o;
    logic [63:0] rd_data_o;
    logic        rd_yumi_i;
    logic [5:0]  axi_awid_o, axi_arid_o, axi_bid_i, axi_rid_i;
    logic [31:0] axi_awaddr_o, axi_araddr_o;
    logic [7:0]  axi_awlen_o, axi_arlen_o, axi_wstrb_o;
    logic [2:0]  axi_awsize_o, axi_arsize_o;
    logic [1:0]  axi_awburst_o, axi_arburst_o, axi_bresp_i, axi_rresp_i;
    logic        axi_awvalid_o, axi_awready_i, axi_wlast_o, axi_wvalid_o, axi_wready_i;
    logic        axi_bvalid_i, axi_bready_o, axi_arvalid_o, axi_arready_i;
    logic        axi_rlast_i, axi_rvalid_i, axi_rready_o, error_o;
    logic [63:0] axi_wdata_o, axi_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0] OP_ACT = 4'b0011, OP_PRE = 4'b0010, OP_RD = 4'b0101,
                           OP_WR = 4'b0100, OP_MRS = 4'b0000;

    bsg_dmc_axi_bridge dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_v_i(cmd_v_i), .cmd_data_i(cmd_data_i), .cmd_ready_o(cmd_ready_o),
        .wr_v_i(wr_v_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
        .rd_v_o(rd_v_o), .rd_data_o(rd_data_o), .rd_yumi_i(rd_yumi_i),
        .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
        .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
        .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i),
        .axi_bready_o(axi_bready_o),
        .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
        .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] mk_cmd(input logic [2:0] bank, input logic [15:0] addr,
                                           input logic [3:0] op);
        return {bank, addr, 1'b1, op, 1'b1, 1'b0};
    endfunction

    task automatic do_reset();
        reset_i = 1'b1;
        cmd_v_i = 0; cmd_data_i = '0; wr_v_i = 0; wr_data_i = '0; rd_yumi_i = 0;
        axi_awready_i = 0; axi_wready_i = 0; axi_bid_i = '0; axi_bresp_i = '0; axi_bvalid_i = 0;
        axi_arready_i = 0; axi_rid_i = '0; axi_rdata_i = '0; axi_rresp_i = '0;
        axi_rlast_i = 0; axi_rvalid_i = 0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] bank, input logic [15:0] addr, input logic [3:0] op);
        int waited;
        cmd_v_i    = 1'b1;
        cmd_data_i = mk_cmd(bank, addr, op);
        waited     = 0;
        #1;
        while (!cmd_ready_o && waited < 20) begin
            @(negedge clk_i); #1; waited++;
        end
        if (!cmd_ready_o) check_eq("cmd_accept_timeout", 64'(cmd_ready_o), 64'd1);
        @(negedge clk_i);
        cmd_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0]  masks [4] = '{8'hFF, 8'h0F, 8'hF0, 8'h81};
    logic [63:0] wd;
    int          n_ar;

    initial begin
        do_reset();
        #1;
        check_eq("rst_error", error_o, 0);
        check_eq("rst_arvalid", axi_arvalid_o, 0);
        check_eq("rst_awvalid", axi_awvalid_o, 0);
        check_eq("rst_wvalid", axi_wvalid_o, 0);
        check_eq("rst_rd_v", rd_v_o, 0);
        check_eq("rst_bready", axi_bready_o, 1);
        check_eq("rst_rready", axi_rready_o, 1);

        // Write burst: ACT bank2 row5, WR col 0x10, BL=8 -> 4 beats
        send_cmd(3'd2, 16'd5, OP_ACT);
        cmd_v_i = 1; cmd_data_i = mk_cmd(3'd2, 16'h0010, OP_WR); axi_awready_i = 0;
        #1;
        check_eq("aw_valid", axi_awvalid_o, 1);
        check_eq("aw_addr", axi_awaddr_o, 64'h0800_5040);
        check_eq("aw_len", axi_awlen_o, 3);
        check_eq("aw_size", axi_awsize_o, 3);
        check_eq("aw_burst", axi_awburst_o, 1);
        check_eq("aw_cmd_held", cmd_ready_o, 0);
        axi_awready_i = 1;
        @(negedge clk_i);
        cmd_v_i = 0; axi_awready_i = 0;
        #1;
        check_eq("aw_valid_after_hs", axi_awvalid_o, 0);
        for (int i = 0; i < 4; i++) begin
            wd = {32'hCAFE_0000 + 32'(i), 32'h1234_0000 + 32'(i)};
            @(negedge clk_i);
            wr_v_i = 1; wr_data_i = {wd, masks[i]};
            #1;
            check_eq("wr_ready_empty", wr_ready_o, 1);
            @(negedge clk_i);
            wr_v_i = 0;
            #1;
            check_eq("w_valid", axi_wvalid_o, 1);
            check_eq("w_data", axi_wdata_o, wd);
            check_eq("w_strb", axi_wstrb_o, masks[i]);
            check_eq("w_last", axi_wlast_o, (i == 3) ? 64'd1 : 64'd0);
            check_eq("wr_ready_full", wr_ready_o, 0);
            axi_wready_i = 1;
            @(negedge clk_i);
            axi_wready_i = 0;
        end
        #1;
        check_eq("w_idle", axi_wvalid_o, 0);
        axi_bvalid_i = 1; axi_bresp_i = 2'b00;
        @(negedge clk_i);
        axi_bvalid_i = 0;
        #1;
        check_eq("b_okay_error", error_o, 0);

        // BL=2 read: arlen 0, one R beat -> one read word
        send_cmd(3'd0, 16'h0001, OP_MRS);
        cmd_v_i = 1; cmd_data_i = mk_cmd(3'd2, 16'h0020, OP_RD); axi_arready_i = 0;
        #1;
        check_eq("ar_valid", axi_arvalid_o, 1);
        check_eq("ar_len_bl2", axi_arlen_o, 0);
        check_eq("ar_addr", axi_araddr_o, 64'h0800_5080);
        check_eq("ar_no_aw", axi_awvalid_o, 0);
        axi_arready_i = 1;
        @(negedge clk_i);
        cmd_v_i = 0; axi_arready_i = 0;
        axi_rvalid_i = 1; axi_rdata_i = 64'h1122_3344_5566_7788; axi_rlast_i = 1;
        #1;
        check_eq("r_ready", axi_rready_o, 1);
        @(negedge clk_i);
        axi_rvalid_i = 0;
        #1;
        check_eq("rd_v", rd_v_o, 1);
        check_eq("rd_data", rd_data_o, 64'h1122_3344_5566_7788);
        check_eq("rd_low_half", 64'(rd_data_o[31:0]), 64'h5566_7788);
        check_eq("r_ready_busy", axi_rready_o, 0);
        rd_yumi_i = 1;
        @(negedge clk_i);
        rd_yumi_i = 0;
        #1;
        check_eq("rd_drained", rd_v_o, 0);
        check_eq("read_error", error_o, 0);

        // Outstanding limit: 5 RDs, rvalid held low
        rd_yumi_i = 1;
        cmd_v_i = 1; cmd_data_i = mk_cmd(3'd2, 16'h0000, OP_RD); axi_arready_i = 1;
        n_ar = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (axi_arvalid_o) n_ar++;
            @(negedge clk_i);
        end
        check_eq("ar_hs_count", n_ar, 4);
        #1;
        check_eq("ar_blocked", axi_arvalid_o, 0);
        axi_rvalid_i = 1; axi_rlast_i = 1; axi_rdata_i = 64'h0;
        #1;
        check_eq("ar_blocked_same_cycle", axi_arvalid_o, 0);
        @(negedge clk_i);
        axi_rvalid_i = 0;
        #1;
        check_eq("ar_fifth_issue", axi_arvalid_o, 1);
        @(negedge clk_i);
        cmd_v_i = 0; axi_arready_i = 0; rd_yumi_i = 0;

        // Closed bank read, sticky error
        do_reset();
        cmd_v_i = 1; cmd_data_i = mk_cmd(3'd5, 16'h0004, OP_RD);
        #1;
        check_eq("closed_rd_arvalid", axi_arvalid_o, 0);
        check_eq("closed_rd_dropped", cmd_ready_o, 1);
        @(negedge clk_i);
        cmd_v_i = 0;
        #1;
        check_eq("closed_rd_error", error_o, 1);
        repeat (5) @(negedge clk_i);
        check_eq("error_sticky", error_o, 1);
        do_reset();
        #1;
        check_eq("error_cleared", error_o, 0);

        // Bad MRS code keeps BL=8
        send_cmd(3'd0, 16'h0007, OP_MRS);
        #1;
        check_eq("bad_mrs_error", error_o, 1);
        send_cmd(3'd1, 16'h0000, OP_ACT);
        cmd_v_i = 1; cmd_data_i = mk_cmd(3'd1, 16'h0000, OP_RD);
        #1;
        check_eq("bad_mrs_bl_kept", axi_arlen_o, 3);
        @(negedge clk_i);
        cmd_v_i = 0;

        // Precharge-all closes bank1
        do_reset();
        send_cmd(3'd0, 16'h0002, OP_ACT);
        send_cmd(3'd1, 16'h0003, OP_ACT);
        send_cmd(3'd0, 16'h0400, OP_PRE);
        cmd_v_i = 1; cmd_data_i = mk_cmd(3'd1, 16'h0000, OP_WR); axi_awready_i = 1;
        #1;
        check_eq("pre_all_awvalid", axi_awvalid_o, 0);
        @(negedge clk_i);
        cmd_v_i = 0; axi_awready_i = 0;
        #1;
        check_eq("pre_all_error", error_o, 1);

        // Reset mid-burst discards the packed beat
        do_reset();
        send_cmd(3'd3, 16'h0001, OP_ACT);
        axi_awready_i = 1;
        send_cmd(3'd3, 16'h0000, OP_WR);
        axi_awready_i = 0;
        wr_v_i = 1; wr_data_i = {64'hDEAD_BEEF_0000_0001, 8'hFF};
        @(negedge clk_i);
        wr_v_i = 0;
        #1;
        check_eq("mid_wvalid", axi_wvalid_o, 1);
        do_reset();
        #1;
        check_eq("mid_rst_wvalid", axi_wvalid_o, 0);
        check_eq("mid_rst_wr_ready", wr_ready_o, 1);

        // SLVERR on B
        axi_bvalid_i = 1; axi_bresp_i = 2'b10;
        @(negedge clk_i);
        axi_bvalid_i = 0;
        #1;
`ifdef BSG_DMC_AXI_RESP_CHECK_EN
        check_eq("bresp_error", error_o, 1);
`else
        check_eq("bresp_ignored", error_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
